// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit multicycle processor and its memory responder.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package proc_pkg;

  // Processor data-bus width; the responder's word width must match it.
  localparam int BUS_W = 16;

  // Instruction opcode field, carried in instruction bits [8:6].
  localparam logic [2:0] OP_LD   = 3'b000;
  localparam logic [2:0] OP_ST   = 3'b001;
  localparam logic [2:0] OP_MVNZ = 3'b010;
  localparam logic [2:0] OP_MV   = 3'b011;
  localparam logic [2:0] OP_MVI  = 3'b100;
  localparam logic [2:0] OP_ADD  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SRL  = 3'b111;

  // Responder sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_IMM   = 3'd3,
    ST_EXEC  = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

endpackage

// File: rtl/proc_mem_responder_word_ram.sv
// Word RAM with a synchronous read port and an independent write port.
// Latency: read data valid one cycle after raddr; write lands on the same edge.
// Backpressure: none; one read and one write accepted every cycle.
//
// Ports:
//   clk   - rising-edge clock
//   raddr - read address, sampled every cycle
//   rdata - registered read data (old contents on a same-address write)
//   we    - write enable
//   waddr - write address
//   wdata - write data
module word_ram #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Non-blocking read and write on the same edge gives read-old-data
  // semantics on a collision.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/proc_mem_responder.sv
// Memory-side sequencer for the multicycle processor: fetches, issues and services ld/st/mvi.
// Latency: FETCH->ISSUE is 2 cycles from Start; EXEC reads return DIN one cycle after ADDR.
// Backpressure: holds each instruction in EXEC until Done (or TIMEOUT cycles, then sticky Error/HALT).
//
// Ports:
//   Clock, Resetn         - rising-edge clock, synchronous active-low reset
//   Start                 - level: run program; low stops after the current instruction
//   Done                  - processor instruction-complete strobe (EXEC only)
//   ADDR, DOUT, W         - processor address, store data, write strobe (EXEC only)
//   LoadEn/Addr/Data      - host RAM write port, honoured in IDLE and HALT
//   DIN, Run              - word to processor, instruction in progress
//   PC                    - address of the next instruction
//   Busy, Halted, Error   - status; Error is the sticky Done-timeout flag
module proc_mem_responder
  import proc_pkg::*;
#(
  parameter int                 ADDR_W    = 7,
  parameter int                 DATA_W    = BUS_W,
  parameter int                 TIMEOUT   = 15,
  parameter logic [DATA_W-1:0]  HALT_WORD = DATA_W'(16'hFFFF)
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Done,
  input  logic [DATA_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DOUT,
  input  logic              W,
  input  logic              LoadEn,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [DATA_W-1:0] LoadData,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  output logic              Halted,
  output logic              Error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt, pc_inc;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              err_nxt;

  logic [ADDR_W-1:0] raddr, waddr;
  logic [DATA_W-1:0] rdata, wdata;
  logic              we;

  // Only the low ADDR_W bits of the processor address reach the RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^ADDR[DATA_W-1:ADDR_W];

  // Natural-width add wraps the PC modulo 2**ADDR_W.
  assign pc_inc = PC + ADDR_W'(1);

  word_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (Clock),
    .raddr (raddr),
    .rdata (rdata),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= ST_IDLE;
      PC    <= '0;
      cnt   <= '0;
      Error <= 1'b0;
    end else begin
      state <= state_nxt;
      PC    <= pc_nxt;
      cnt   <= cnt_nxt;
      Error <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    cnt_nxt   = cnt;
    err_nxt   = Error;
    raddr     = ADDR[ADDR_W-1:0];
    waddr     = LoadAddr;
    wdata     = LoadData;
    we        = 1'b0;
    DIN       = '0;
    Run       = 1'b0;
    Busy      = 1'b0;
    Halted    = 1'b0;

    case (state)
      ST_IDLE: begin
        we = LoadEn;
        if (Start) begin
          state_nxt = ST_FETCH;
        end
      end

      ST_FETCH: begin
        Busy      = 1'b1;
        raddr     = PC;
        state_nxt = ST_ISSUE;
      end

      ST_ISSUE: begin
        Busy = 1'b1;
        if (rdata == HALT_WORD) begin
          state_nxt = ST_HALT;
        end else begin
          DIN    = rdata;
          Run    = 1'b1;
          pc_nxt = pc_inc;
          // Prefetch the following word so an mvi immediate is ready in IMM.
          raddr     = pc_inc;
          state_nxt = (rdata[8:6] == OP_MVI) ? ST_IMM : ST_EXEC;
        end
      end

      ST_IMM: begin
        Busy      = 1'b1;
        DIN       = rdata;
        Run       = 1'b1;
        pc_nxt    = pc_inc;
        state_nxt = ST_EXEC;
      end

      ST_EXEC: begin
        Busy  = 1'b1;
        Run   = 1'b1;
        DIN   = rdata;
        we    = W;
        waddr = ADDR[ADDR_W-1:0];
        wdata = DOUT;
        // cnt counts EXEC cycles already spent; Done takes priority over expiry.
        if (Done) begin
          cnt_nxt   = '0;
          state_nxt = Start ? ST_FETCH : ST_IDLE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
          state_nxt = ST_HALT;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_HALT: begin
        Halted = 1'b1;
        we     = LoadEn;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // A store or host write presented on a reset cycle must not land.
    if (!Resetn) begin
      we = 1'b0;
    end
  end

endmodule
